// File: rtl/product_rx_pkg.sv
// Shared types and constants for the product-link serial receiver.
package product_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int unsigned DATA_BITS = 8;

    // Width of a counter that must reach clks_per_bit-1.
    function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module rx_sync #(
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two register stages give the first stage a full cycle to settle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/product_rx.sv
// Oversampling serial receiver for the product link: start bit, 8 data bits
// LSB first, optional even parity, stop bit. Reports each frame with exactly
// one of rx_valid / parity_err / frame_err.
module product_rx
    import product_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned     CW        = cnt_width(CLKS_PER_BIT);
    localparam int unsigned     BW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_tick;
    rx_state_t            r_state;
    rx_state_t            w_next_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [7:0]           r_rx_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;

    rx_sync #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk   (CLK),
        .i_rst_n (rst_n),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    // Sample point: mid start bit in START, end of a full bit period otherwise.
    always_comb begin
        w_tick = 1'b0;
        case (r_state)
            START:               w_tick = (r_cnt == HALF_LAST);
            DATA, PARITY, STOP:  w_tick = (r_cnt == BIT_LAST);
            default:             w_tick = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_next_state = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick && (r_bit_idx == LAST_BIT)) begin
                    w_next_state = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Bit timing, data capture, parity tracking and registered result strobes.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_rx_data <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    r_par_err <= 1'b0;
                end
                START: begin
                    r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
                end
                DATA: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + BW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_par_err <= (w_rx_s != (^r_shift));
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_rx_data <= r_shift;
                            if (r_par_err) begin
                                r_perr <= 1'b1;
                            end else begin
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Output drive.
    always_comb begin
        busy       = (r_state != IDLE);
        rx_data    = r_rx_data;
        rx_valid   = r_valid;
        frame_err  = r_ferr;
        parity_err = r_perr;
    end

endmodule
